// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage. Holds the EX->MEM pipeline
//            registers, drives the data-memory port through a req/gnt/rvalid
//            handshake, builds byte enables and replicated store data, aligns
//            and extends load data, and flags misaligned HALF/WORD accesses.
// Ports    : clk_i/rst_n_i           clock, asynchronous active-low reset
//            *_ex_i                  instruction fields from the EX stage
//            stall_mem_i/flush_mem_i controller hold / bubble insertion
//            dmem_*                  data-memory request/response port
//            *_mem_o                 registered writeback set to the WB stage
//            mem_rdata_mem_o         aligned, extended load data
//            mem_busy_o              stall request while a transaction runs
//            trap_mem_o, load_misaligned_o, store_misaligned_o  trap + cause
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
   parameter int unsigned MISALIGN_TRAP = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [4:0]  rd_addr_ex_i,
   input  logic        rd_dst_bank_ex_i,
   input  logic [31:0] alu_result_ex_i,
   input  logic        mem_wen_ex_i,
   input  logic [1:0]  mem_data_type_ex_i,
   input  logic        mem_sign_extend_ex_i,
   input  logic [31:0] mem_wdata_ex_i,
   input  logic        reg_alu_wen_ex_i,
   input  logic        reg_mem_wen_ex_i,
   input  logic        valid_ex_i,
   input  logic        stall_mem_i,
   input  logic        flush_mem_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic [4:0]  rd_addr_mem_o,
   output logic        rd_dst_bank_mem_o,
   output logic [31:0] alu_result_mem_o,
   output logic [31:0] mem_rdata_mem_o,
   output logic        reg_alu_wen_mem_o,
   output logic        reg_mem_wen_mem_o,
   output logic        valid_mem_o,
   output logic        mem_busy_o,
   output logic        trap_mem_o,
   output logic        load_misaligned_o,
   output logic        store_misaligned_o
);

   localparam logic TRAP_EN = (MISALIGN_TRAP != 0);

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_WAIT_GNT    = 2'd1,
      S_WAIT_RVALID = 2'd2,
      S_DONE        = 2'd3
   } state_e;

   state_e      state_q, state_d;

   // EX->MEM pipeline registers
   logic [4:0]  rd_addr_q;
   logic        rd_dst_bank_q;
   logic [31:0] alu_result_q;
   logic        mem_wen_q;
   logic [1:0]  mem_data_type_q;
   logic        mem_sign_extend_q;
   logic [31:0] mem_wdata_q;
   logic        reg_alu_wen_q;
   logic        reg_mem_wen_q;
   logic        valid_q;
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_addr_q         <= '0;
         rd_dst_bank_q     <= 1'b0;
         alu_result_q      <= '0;
         mem_wen_q         <= 1'b0;
         mem_data_type_q   <= '0;
         mem_sign_extend_q <= 1'b0;
         mem_wdata_q       <= '0;
         reg_alu_wen_q     <= 1'b0;
         reg_mem_wen_q     <= 1'b0;
         valid_q           <= 1'b0;
      end else if (!stall_mem_i) begin
         if (flush_mem_i) begin
            // Bubble: kill every side effect, leave the data fields alone.
            mem_wen_q     <= 1'b0;
            reg_alu_wen_q <= 1'b0;
            reg_mem_wen_q <= 1'b0;
            valid_q       <= 1'b0;
         end else begin
            rd_addr_q         <= rd_addr_ex_i;
            rd_dst_bank_q     <= rd_dst_bank_ex_i;
            alu_result_q      <= alu_result_ex_i;
            mem_wen_q         <= mem_wen_ex_i;
            mem_data_type_q   <= mem_data_type_ex_i;
            mem_sign_extend_q <= mem_sign_extend_ex_i;
            mem_wdata_q       <= mem_wdata_ex_i;
            reg_alu_wen_q     <= reg_alu_wen_ex_i;
            reg_mem_wen_q     <= reg_mem_wen_ex_i;
            valid_q           <= valid_ex_i;
         end
      end
   end

   // Access classification
   logic w_is_half, w_is_word, w_mem_op, w_mis_raw, w_misaligned, w_access;

   assign w_is_half    = (mem_data_type_q == 2'd1);
   assign w_is_word    = mem_data_type_q[1];   // encoding 3 is handled as WORD
   assign w_mem_op     = mem_wen_q | reg_mem_wen_q;
   assign w_mis_raw    = (w_is_half & alu_result_q[0]) |
                         (w_is_word & (alu_result_q[1:0] != 2'b00));
   assign w_misaligned = TRAP_EN & w_mis_raw;
   assign w_access     = valid_q & w_mem_op & ~w_misaligned;

   assign trap_mem_o         = valid_q & w_misaligned & w_mem_op;
   assign store_misaligned_o = trap_mem_o & mem_wen_q;
   assign load_misaligned_o  = trap_mem_o & ~mem_wen_q;

   // Memory port, driven straight from the MEM registers so it stays stable
   // for as long as the stage is stalled.
   assign dmem_addr_o = {alu_result_q[31:2], 2'b00};
   assign dmem_we_o   = mem_wen_q;

   always_comb begin
      dmem_be_o    = 4'b1111;
      dmem_wdata_o = mem_wdata_q;
      case (mem_data_type_q)
         2'd0: begin
            dmem_be_o    = 4'b0001 << alu_result_q[1:0];
            dmem_wdata_o = {4{mem_wdata_q[7:0]}};
         end
         2'd1: begin
            dmem_be_o    = alu_result_q[1] ? 4'b1100 : 4'b0011;
            dmem_wdata_o = {2{mem_wdata_q[15:0]}};
         end
         default: begin
            dmem_be_o    = 4'b1111;
            dmem_wdata_o = mem_wdata_q;
         end
      endcase
   end

   // Handshake FSM
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      dmem_req_o = 1'b0;
      mem_busy_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            dmem_req_o = w_access;
            mem_busy_o = w_access;
            if (w_access) begin
               state_d = dmem_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
            end
         end
         S_WAIT_GNT: begin
            // Request may not be retracted once raised.
            dmem_req_o = 1'b1;
            mem_busy_o = 1'b1;
            if (dmem_gnt_i) begin
               state_d = S_WAIT_RVALID;
            end
         end
         S_WAIT_RVALID: begin
            mem_busy_o = ~dmem_rvalid_i;
            if (dmem_rvalid_i) begin
               // If the stage is held by someone else, park in DONE so the
               // still-present instruction is not issued a second time.
               state_d = stall_mem_i ? S_DONE : S_IDLE;
            end
         end
         S_DONE: begin
            if (!stall_mem_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rdata_q <= '0;
      end else if ((state_q == S_WAIT_RVALID) && dmem_rvalid_i) begin
         rdata_q <= dmem_rdata_i;
      end
   end

   // Load alignment and extension
   logic [31:0] w_rsrc, w_rshift;

   assign w_rsrc   = (state_q == S_WAIT_RVALID) ? dmem_rdata_i : rdata_q;
   assign w_rshift = w_rsrc >> {alu_result_q[1:0], 3'b000};

   always_comb begin
      mem_rdata_mem_o = w_rshift;
      case (mem_data_type_q)
         2'd0:    mem_rdata_mem_o = {{24{mem_sign_extend_q & w_rshift[7]}}, w_rshift[7:0]};
         2'd1:    mem_rdata_mem_o = {{16{mem_sign_extend_q & w_rshift[15]}}, w_rshift[15:0]};
         default: mem_rdata_mem_o = w_rshift;
      endcase
   end

   assign rd_addr_mem_o     = rd_addr_q;
   assign rd_dst_bank_mem_o = rd_dst_bank_q;
   assign alu_result_mem_o  = alu_result_q;
   assign reg_alu_wen_mem_o = reg_alu_wen_q;
   assign reg_mem_wen_mem_o = reg_mem_wen_q;
   assign valid_mem_o       = valid_q;

endmodule
`default_nettype wire
